// File: rtl/demux_1to4_buf.sv
// ---------------------------------------------------------------------------
// demux_1to4_buf
//
// Registered 1-to-4 demultiplexer. One producer stream is steered into one
// of four single-entry holding buffers, or into all four at once on a
// broadcast. Each buffer drains through its own valid/ready port. A delivery
// counter per channel counts completed output transfers.
//
// Handshake semantics (input and all four outputs):
//   A transfer happens at a rising edge where valid and ready are both 1.
//   valid never depends on ready.
//   in_ready is a combinational function of in_sel, in_bcast, the buffer
//   flags and out_ready. It never looks at in_valid or in_data.
//   A held word (out_valid=1, out_ready=0) stays stable until it is taken.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    DATA_W word offered by the producer
//   in_sel     destination channel 0..3 (ignored on broadcast)
//   in_bcast   1 = write the word to all four channels
//   in_valid   producer offers a word
//   in_ready   the offered word would be accepted this cycle
//   out_data   4*DATA_W, channel k at [k*DATA_W +: DATA_W]
//   out_valid  bit k: channel k buffer holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_cnt    4*CNT_W, channel k delivery count at [k*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module demux_1to4_buf #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_bcast,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*CNT_W-1:0]  out_cnt
);

  // Per-channel state. Kept as separate per-channel registers so that each
  // channel has exactly one sequential process driving it.
  logic [DATA_W-1:0] buf_q  [4];
  logic              full_q [4];
  logic [CNT_W-1:0]  cnt_q  [4];

  logic [3:0] full_vec;
  logic [3:0] avail;
  logic [3:0] sel_onehot;
  logic [3:0] load;
  logic [3:0] drain;
  logic       accept;

  always_comb begin
    full_vec = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      full_vec[k] = full_q[k];
    end
  end

  // A channel can take a word if it is empty, or if its current word leaves
  // at this same edge (pass-through reload).
  assign avail = ~full_vec | out_ready;

  always_comb begin
    sel_onehot = 4'b0000;
    sel_onehot[in_sel] = 1'b1;
  end

  // Broadcast is all-or-nothing: every channel must be able to accept.
  always_comb begin
    if (in_bcast) begin
      in_ready = &avail;
    end else begin
      in_ready = avail[in_sel];
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      load = in_bcast ? 4'b1111 : sel_onehot;
    end
  end

  // out_ready on an empty channel is not a transfer.
  assign drain = full_vec & out_ready;

  for (genvar k = 0; k < 4; k++) begin : g_chan
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_q[k]  <= '0;
        full_q[k] <= 1'b0;
        cnt_q[k]  <= '0;
      end else begin
        if (load[k]) begin
          buf_q[k] <= in_data;
        end
        // A load in the same edge as a drain keeps the buffer full with the
        // new word; otherwise a drain empties it.
        if (load[k]) begin
          full_q[k] <= 1'b1;
        end else if (drain[k]) begin
          full_q[k] <= 1'b0;
        end
        // Counter wraps silently at all-ones.
        if (drain[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end

    assign out_data[k*DATA_W +: DATA_W] = buf_q[k];
    assign out_cnt[k*CNT_W +: CNT_W]    = cnt_q[k];
    assign out_valid[k]                 = full_q[k];
  end

endmodule
